cfg_chain_loader: RTL

//  Master/driver end of the serial configuration chain (prog_in/prog_clk/prog_en/prog_out)

---
 rtl/cfg_chain_pkg.sv | 27 ++
 rtl/prog_clk_phase.sv | 43 ++++
 rtl/cfg_chain_loader.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/cfg_chain_pkg.sv
// Shared types and sizing helpers for the configuration chain loader.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package cfg_chain_pkg;

  // Loader sequencing: one SETUP/HIGH/LOW triplet per chain bit, FETCH between words.
  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SETUP,
    HIGH,
    LOW,
    FLUSH,
    DONE
  } state_t;

  // Number of input words consumed by one full chain load.
  function automatic int words_per_chain(input int chain_len, input int word_w);
    return (chain_len + word_w - 1) / word_w;
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/prog_clk_phase.sv
// Phase timer for the chain shift clock: flags the last cycle of a CLK_DIV-long phase.
// Latency: phase_done asserts on the CLK_DIV-th consecutive cycle of run.
// Backpressure: hold freezes the counter on its last cycle so phase_done stays high.
//
// Ports:
//   clk, rst_n  system clock, async active-low reset
//   run         high while a HIGH or LOW phase is in progress; low clears the count
//   hold        keep the current count (used while the loader is stalled)
//   phase_done  current cycle is the last cycle of the phase
module prog_clk_phase
  import cfg_chain_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic hold,
  output logic phase_done
);

  localparam int CW = cnt_w(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  assign phase_done = run && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!run) begin
      cnt <= '0;
    end else if (hold) begin
      cnt <= cnt;
    end else if (phase_done) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/cfg_chain_loader.sv
// Drives the serial config chain: shifts stream words out LSB-first, returns old chain bits.
// Latency: 1 + 2*CLK_DIV cycles per bit, plus one FETCH cycle per word; done follows the final readback.
// Backpressure: s_ready only in FETCH; a pending readback word stalls the chain with prog_clk low.
//
// Ports:
//   clk, rst_n          system clock, async active-low reset
//   start               pulse to begin a CHAIN_LEN-bit load (ignored while busy)
//   s_data/valid/ready  bitstream words in, bit 0 shifted first
//   prog_in/clk/en      serial data, shift clock and enable to the chain head
//   prog_out            chain tail (old configuration bits)
//   m_data/valid/ready  readback words out, bit 0 = first bit captured
//   busy, done          load in progress / one-cycle completion pulse
module cfg_chain_loader
  import cfg_chain_pkg::*;
#(
  parameter int CHAIN_LEN = 19,
  parameter int WORD_W    = 8,
  parameter int CLK_DIV   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              prog_in,
  output logic              prog_clk,
  output logic              prog_en,
  input  logic              prog_out,
  output logic [WORD_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              busy,
  output logic              done
);

  localparam int BW = cnt_w(CHAIN_LEN);
  localparam int IW = cnt_w(WORD_W);
  localparam logic [BW-1:0] BIT_LAST = BW'(CHAIN_LEN - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(WORD_W - 1);

  state_t            state;
  state_t            state_nxt;
  logic [BW-1:0]     bit_cnt;
  logic [IW-1:0]     bit_idx;
  logic [IW-1:0]     idx_inc;
  logic [WORD_W-1:0] word_q;
  logic [WORD_W-1:0] rb_acc;

  logic phase_run;
  logic phase_done;
  logic phase_hold;
  logic s_fire;
  logic last_bit;
  logic word_end;
  logic rb_need;
  logic rb_load;
  logic low_exit;

  assign s_fire   = s_valid && s_ready;
  assign last_bit = (bit_cnt == BIT_LAST);
  assign word_end = (bit_idx == IDX_LAST);
  assign idx_inc  = bit_idx + IW'(1);

  // The end of a LOW phase at a word boundary (or the final bit) hands the
  // accumulated readback word to m_data. If the previous word has not been
  // taken, the phase timer is frozen and the chain waits with prog_clk low.
  assign rb_need    = (state == LOW) && phase_done && (last_bit || word_end);
  assign rb_load    = rb_need && (!m_valid || m_ready);
  assign phase_hold = rb_need && m_valid && !m_ready;
  assign low_exit   = (state == LOW) && phase_done && !phase_hold;
  assign phase_run  = (state == HIGH) || (state == LOW);

  prog_clk_phase #(
    .CLK_DIV (CLK_DIV)
  ) u_phase (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (phase_run),
    .hold       (phase_hold),
    .phase_done (phase_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FETCH;
      FETCH:   if (s_fire) state_nxt = SETUP;
      SETUP:   state_nxt = HIGH;
      HIGH:    if (phase_done) state_nxt = LOW;
      LOW: begin
        if (low_exit) begin
          if (last_bit)      state_nxt = FLUSH;
          else if (word_end) state_nxt = FETCH;
          else               state_nxt = SETUP;
        end
      end
      FLUSH:   if (m_valid && m_ready) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Chain-facing controls are registered from the next state so prog_clk is
  // a clean flop output and prog_en/prog_clk drop together on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prog_clk <= 1'b0;
      prog_en  <= 1'b0;
      s_ready  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      prog_clk <= (state_nxt == HIGH);
      prog_en  <= !(state_nxt inside {IDLE, DONE});
      s_ready  <= (state_nxt == FETCH);
      busy     <= !(state_nxt inside {IDLE, DONE});
      done     <= (state_nxt == DONE);
    end
  end

  // prog_in is updated on entry to SETUP, a full cycle before the rising edge
  // of prog_clk, and held through HIGH. prog_out is sampled during SETUP, i.e.
  // before that edge, so bit i captures the old configuration bit i.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q  <= '0;
      rb_acc  <= '0;
      bit_cnt <= '0;
      bit_idx <= '0;
      prog_in <= 1'b0;
      m_data  <= '0;
      m_valid <= 1'b0;
    end else begin
      if ((state == IDLE) && start) begin
        bit_cnt <= '0;
        bit_idx <= '0;
        rb_acc  <= '0;
      end

      if (s_fire) begin
        word_q  <= s_data;
        bit_idx <= '0;
        prog_in <= s_data[0];
      end

      if (state == SETUP) begin
        rb_acc[bit_idx] <= prog_out;
      end

      if (low_exit && !last_bit) begin
        bit_cnt <= bit_cnt + BW'(1);
        if (!word_end) begin
          bit_idx <= idx_inc;
          prog_in <= word_q[idx_inc];
        end
      end

      // Loading a new word and retiring the old one can coincide; the load wins.
      if (rb_load) begin
        m_data  <= rb_acc;
        rb_acc  <= '0;
        m_valid <= 1'b1;
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule
